// File: rtl/fwd_hazard_unit_pkg.sv
// Shared pipeline constants for the ID-stage forwarding/hazard unit.
// Holds the register-file select code, default register index width and stage indices.
package fwd_hazard_unit_pkg;

    localparam int FWD_SEL_RF = 0;
    localparam int REG_AW_DEF = 5;

    localparam int STG_EX  = 0;
    localparam int STG_MEM = 1;
    localparam int STG_WB  = 2;

endpackage

// File: rtl/fwd_hazard_unit_src_sel.sv
// fwd_src_sel: priority match of one ID source operand over the downstream stages.
// Ports: src_i/src_en_i operand, stg_* stage writers, sel_o select, hit_o match, not_ready_o.
module fwd_src_sel
    import fwd_hazard_unit_pkg::*;
#(
    parameter int NUM_STAGE = 3,
    parameter int REG_AW    = REG_AW_DEF,
    parameter int SEL_W     = 2
) (
    input  logic [REG_AW-1:0]           src_i,
    input  logic                        src_en_i,
    input  logic [NUM_STAGE-1:0]        stg_gr_we_i,
    input  logic [NUM_STAGE*REG_AW-1:0] stg_dest_i,
    input  logic [NUM_STAGE-1:0]        stg_data_ok_i,
    output logic [SEL_W-1:0]            sel_o,
    output logic                        hit_o,
    output logic                        not_ready_o
);

    // Walk from oldest to youngest so the youngest (lowest k) match wins.
    always_comb begin
        sel_o       = SEL_W'(FWD_SEL_RF);
        hit_o       = 1'b0;
        not_ready_o = 1'b0;
        for (int k = NUM_STAGE - 1; k >= 0; k--) begin
            if (src_en_i && (src_i != '0) && stg_gr_we_i[k] &&
                (stg_dest_i[k*REG_AW +: REG_AW] == src_i)) begin
                sel_o       = SEL_W'(k + 1);
                hit_o       = 1'b1;
                not_ready_o = !stg_data_ok_i[k];
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: ID-stage forwarding select, load-use stall and long-latency scoreboard.
// Ports: id_* ID operand/issue info, stg_* downstream writers, lw_* long-op writeback,
// sb_flush cancel; outputs fwd_sel, id_stall, sb_pending. FWD_HAZARD_PERF_EN adds perf counters.
module fwd_hazard_unit
    import fwd_hazard_unit_pkg::*;
#(
    parameter int NUM_SRC   = 3,
    parameter int NUM_STAGE = 3,
    parameter int REG_AW    = REG_AW_DEF,
    parameter int SEL_W     = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        id_valid,
    input  logic [NUM_SRC*REG_AW-1:0]   id_src,
    input  logic [NUM_SRC-1:0]          id_src_en,
    input  logic                        id_fire,
    input  logic                        id_long,
    input  logic [REG_AW-1:0]           id_dest,
    input  logic [NUM_STAGE-1:0]        stg_gr_we,
    input  logic [NUM_STAGE*REG_AW-1:0] stg_dest,
    input  logic [NUM_STAGE-1:0]        stg_data_ok,
    input  logic                        lw_done,
    input  logic [REG_AW-1:0]           lw_dest,
    input  logic                        sb_flush,
`ifdef FWD_HAZARD_PERF_EN
    output logic [31:0]                 perf_stall_cnt,
    output logic [31:0]                 perf_fwd_cnt,
`endif
    output logic [NUM_SRC*SEL_W-1:0]    fwd_sel,
    output logic                        id_stall,
    output logic [2**REG_AW-1:0]        sb_pending
);

    localparam int NREG = 2**REG_AW;

    logic [NREG-1:0]    sb_q;
    logic [NREG-1:0]    sb_d;
    logic [NREG-1:0]    sb_eff;
    logic [NUM_SRC-1:0] src_hz;
    logic               waw_hz;

    // While reset is held, hazards are judged against an empty scoreboard.
    assign sb_eff     = reset ? '0 : sb_q;
    assign sb_pending = sb_q;

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        logic [REG_AW-1:0] src;
        logic              hit;
        logic              nr;

        assign src = id_src[gi*REG_AW +: REG_AW];

        fwd_src_sel #(
            .NUM_STAGE (NUM_STAGE),
            .REG_AW    (REG_AW),
            .SEL_W     (SEL_W)
        ) u_sel (
            .src_i         (src),
            .src_en_i      (id_src_en[gi]),
            .stg_gr_we_i   (stg_gr_we),
            .stg_dest_i    (stg_dest),
            .stg_data_ok_i (stg_data_ok),
            .sel_o         (fwd_sel[gi*SEL_W +: SEL_W]),
            .hit_o         (hit),
            .not_ready_o   (nr)
        );

        // A stage match shadows the scoreboard: a younger in-flight writer
        // supersedes the pending long-latency result.
        assign src_hz[gi] = hit ? nr :
                            (id_src_en[gi] && (src != '0) && sb_eff[src]);
    end

    assign waw_hz   = id_long && (id_dest != '0) && sb_eff[id_dest];
    assign id_stall = id_valid && ((|src_hz) || waw_hz);

    // Set beats clear; flush beats everything; r0 never pends.
    always_comb begin
        sb_d = sb_q;
        if (lw_done) begin
            sb_d[lw_dest] = 1'b0;
        end
        if (id_fire && id_long && (id_dest != '0)) begin
            sb_d[id_dest] = 1'b1;
        end
        if (sb_flush) begin
            sb_d = '0;
        end
        sb_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

    a_no_fire_on_stall: assert property (
        @(posedge clk) disable iff (reset) !(id_fire && id_stall));

`ifdef FWD_HAZARD_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;
    logic [31:0] fwd_cnt_q;
    logic [31:0] fwd_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        fwd_cnt_d   = fwd_cnt_q;
        if (id_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (id_fire && (|fwd_sel) && (fwd_cnt_q != '1)) begin
            fwd_cnt_d = fwd_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor to the ID-stage forwarding selector.
- Per ID source operand: picks the youngest matching writer among NUM_STAGE downstream stages (stage 0 = EX, nearest) and raises a stall when that writer's data is not yet available (load-use).
- Holds a sequential scoreboard of pending long-latency writes (div/mod, uncached loads) so dependents and WAW hazards stall until the result is written back.
- Sits beside the ID stage; its stall output feeds ID ready_go.

Parameters:
NUM_SRC, 3, number of ID source operands checked (rj, rk, rd-as-source)
NUM_STAGE, 3, number of forwarding stages, index 0 = youngest (EX)
REG_AW, 5, register index width; register count = 2**REG_AW
SEL_W, 2, fwd select width, must satisfy 2**SEL_W >= NUM_STAGE+1

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
id_valid  in  1  ID holds a valid instruction
id_src  in  NUM_SRC*REG_AW  source register indices, operand i at bits [i*REG_AW +: REG_AW]
id_src_en  in  NUM_SRC  operand i is actually read
id_fire  in  1  ID instruction moves to EX this cycle
id_long  in  1  ID instruction is long-latency
id_dest  in  REG_AW  ID instruction destination
stg_gr_we  in  NUM_STAGE  stage k writes a GPR (already qualified by stage valid)
stg_dest  in  NUM_STAGE*REG_AW  stage k destination
stg_data_ok  in  NUM_STAGE  stage k result is forwardable this cycle
lw_done  in  1  long-latency result written back this cycle
lw_dest  in  REG_AW  register being completed
sb_flush  in  1  exception/ertn flush; long ops are cancelled
fwd_sel  out  NUM_SRC*SEL_W  per operand: 0 = register file, k+1 = stage k
id_stall  out  1  ID must not advance
sb_pending  out  2**REG_AW  scoreboard state, bit r = r has a pending long write

Behaviour:
- Match(i,k) = id_src_en[i] & stg_gr_we[k] & stg_dest[k]==src_i & src_i!=0.
- fwd_sel[i] = k+1 for the lowest k with Match(i,k); 0 if none. Combinational, zero latency.
- Operand i hazard = (selected stage k has stg_data_ok[k]==0) | (id_src_en[i] & sb_pending[src_i]).
- A stage match takes priority over the scoreboard only when its stg_data_ok is 1.
- WAW hazard = id_long & id_dest!=0 & sb_pending[id_dest].
- id_stall = id_valid & (any operand hazard | WAW hazard). Combinational.
- r0 is never forwarded, never pending, never stalls.
- Scoreboard: register array sb_pending, the only sequential state besides the optional counters.
  - Set: next cycle bit id_dest when id_fire & id_long & id_dest!=0.
  - Clear: next cycle bit lw_dest when lw_done.
  - Set and clear of the same register in one cycle: set wins.
  - sb_flush: all bits clear next cycle, overriding any same-cycle set.
  - id_fire while id_stall is high is illegal. Simulation assertion only; set is still applied.
- Reset: sb_pending = 0, counters = 0.
  - Combinational outputs follow inputs during reset, evaluated with sb_pending = 0.
  - Reset in the middle of a long op drops its pending bit. The issuing unit must be reset too.

Optional Feature:
- Macro: FWD_HAZARD_PERF_EN.
- Defined: adds outputs perf_stall_cnt (32) and perf_fwd_cnt (32).
  - perf_stall_cnt increments each cycle id_stall=1.
  - perf_fwd_cnt increments each cycle id_fire=1 and any fwd_sel!=0.
  - Both saturate at 0xFFFFFFFF and clear on reset.
- Undefined: ports and registers are absent; all other behaviour is identical.

Decomposition:
- Shared pipeline package holds:
  - FWD_SEL_RF = 0 constant
  - REG_AW default
  - Stage index constants EX=0, MEM=1, WB=2
- Sub-module fwd_src_sel: one operand's priority match over NUM_STAGE stages, producing sel and a not-ready flag. Instantiated NUM_SRC times in a generate loop.
- Scoreboard logic stays in the top module.

Test Plan:
1. EX (k0) and MEM (k1) both write r5, both data_ok=1, src0=r5 -> fwd_sel[0]=1, id_stall=0.
2. EX load to r7 with stg_data_ok[0]=0, src1=r7, id_valid=1 -> id_stall=1.
   - Next cycle load in MEM with data_ok=1 -> fwd_sel[1]=2, id_stall=0.
3. id_fire & id_long with id_dest=r9 -> sb_pending[9]=1 next cycle.
   - Dependent src0=r9 -> stall every cycle until lw_done, lw_dest=9.
   - Stall drops the cycle after lw_done.
4. r9 pending; same cycle lw_done lw_dest=9 and a new long issue to r9 -> sb_pending[9] stays 1.
5. r3 and r4 pending, sb_flush with a same-cycle long issue to r6 -> sb_pending all 0 next cycle.
6. src=r0 with a stage writing r0 and data_ok=0 -> fwd_sel=0, id_stall=0.
   - With FWD_HAZARD_PERF_EN: 10 stall cycles -> perf_stall_cnt=10.
